// File: rtl/note_sequencer.sv
// note_sequencer: steps through a programmable {hp, dur} table and drives one freq_synth's hp/active.
// Optional macro SEQ_LOOP_EN: the melody repeats until stop, and start while busy restarts it at step 0.
module note_sequencer #(
  parameter int AW        = 4,
  parameter int DUR_TICKS = 256,
  parameter int GAP_TICKS = 16
) (
  input  logic          synth_clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [10:0]   wr_data,
  input  logic [AW-1:0] len_m1,
  input  logic          start,
  input  logic          stop,
  output logic [6:0]    hp,
  output logic          active,
  output logic [AW-1:0] step,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH    = 1 << AW;
  localparam int NOTE_MAX = 16 * DUR_TICKS - 1;
  localparam int GAP_MAX  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam int CNT_MAX  = (NOTE_MAX > GAP_MAX) ? NOTE_MAX : GAP_MAX;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [6:0]    hp_reg, hp_next;
  logic          active_reg, active_next;
  logic [AW-1:0] step_reg, step_next;
  logic [AW-1:0] len_reg, len_next;
  logic          done_reg, done_next;
  logic          step_end;

  logic [10:0]   table_mem [DEPTH];
  logic [10:0]   rd_word;
  logic [6:0]    rd_hp;
  logic [3:0]    rd_dur;
  logic [CW-1:0] note_load;

  // Step table is not reset; a write in the same cycle as a LOAD read yields the old word.
  always_ff @(posedge synth_clk) begin
    if (wr_en) begin
      table_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_word   = table_mem[step_reg];
  assign rd_hp     = rd_word[10:4];
  assign rd_dur    = rd_word[3:0];
  assign note_load = CW'((int'(rd_dur) + 1) * DUR_TICKS - 1);

  always_ff @(posedge synth_clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hp_reg     <= 7'd1;
      active_reg <= 1'b0;
      step_reg   <= '0;
      len_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hp_reg     <= hp_next;
      active_reg <= active_next;
      step_reg   <= step_next;
      len_reg    <= len_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hp_next     = hp_reg;
    active_next = active_reg;
    step_next   = step_reg;
    len_next    = len_reg;
    done_next   = 1'b0;
    step_end    = 1'b0;

    if (stop) begin
      state_next  = IDLE;
      active_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_next   = len_m1;
            step_next  = '0;
            state_next = LOAD;
          end
        end
        LOAD: begin
          // A rest step parks hp at 1 so freq_synth never sees a zero half-period.
          hp_next     = (rd_hp == 7'd0) ? 7'd1 : rd_hp;
          active_next = (rd_hp != 7'd0);
          cnt_next    = note_load;
          state_next  = PLAY;
        end
        PLAY: begin
          if (cnt_reg == '0) begin
            active_next = 1'b0;
            if (GAP_TICKS > 0) begin
              cnt_next   = GAP_LOAD;
              state_next = GAP;
            end else begin
              step_end = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            step_end = 1'b1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      if (step_end) begin
        if (step_reg == len_reg) begin
          done_next = 1'b1;
`ifdef SEQ_LOOP_EN
          step_next  = '0;
          state_next = LOAD;
`else
          state_next = IDLE;
`endif
        end else begin
          step_next  = step_reg + AW'(1);
          state_next = LOAD;
        end
      end

`ifdef SEQ_LOOP_EN
      // Restart overrides whatever the current state decided; the old note is silenced.
      if (start && (state_reg != IDLE)) begin
        len_next    = len_m1;
        step_next   = '0;
        hp_next     = hp_reg;
        active_next = 1'b0;
        done_next   = 1'b0;
        state_next  = LOAD;
      end
`endif
    end
  end

  assign hp     = hp_reg;
  assign active = active_reg;
  assign step   = step_reg;
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a per-step timeline model predicts one record per
// played step (plus done pulses); a forked monitor segments the DUT outputs and compares.
module tb_note_sequencer;
  localparam int AW = 4;
  localparam int DT = 4;
  localparam int GT = 2;

  logic          synth_clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [10:0]   wr_data = '0;
  logic [AW-1:0] len_m1 = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [6:0]    hp;
  logic          active;
  logic [AW-1:0] step;
  logic          busy;
  logic          done;

  note_sequencer #(.AW(AW), .DUR_TICKS(DT), .GAP_TICKS(GT)) dut (
    .synth_clk(synth_clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_m1(len_m1), .start(start), .stop(stop), .hp(hp), .active(active), .step(step),
    .busy(busy), .done(done)
  );

  always #5 synth_clk = ~synth_clk;

  typedef struct {
    bit is_done;
    int step;
    int hp;
    int act;
    int first;
    int cyc;
  } rec_t;

  rec_t        exp_q[$];
  logic [10:0] tbl [16];
  int          checks = 0;
  int          errors = 0;
  int          hp_zero_seen = 0;
  int          m_hp = 1;
  int          m_step = 0;

  function automatic string fmt(input rec_t r);
    if (r.is_done) return "done";
    return $sformatf("note step=%0d hp=%0d act=%0d first=%0d cyc=%0d", r.step, r.hp, r.act, r.first, r.cyc);
  endfunction

  function automatic rec_t done_rec();
    rec_t r;
    r.is_done = 1'b1; r.step = 0; r.hp = 0; r.act = 0; r.first = 0; r.cyc = 0;
    return r;
  endfunction

  // Expected records for one playback from step 0. cut = offset (from the first LOAD cycle)
  // of the last busy cycle when stop/reset/restart ends it early; -1 = natural end.
  task automatic model_pass(input int len, input int cut, input bit loop_mode);
    int off, s, d, hpf, n, p, b, guard;
    rec_t r;
    off = 0; s = 0; guard = 0;
    while (guard < 200) begin
      guard++;
      hpf = int'(tbl[s][10:4]);
      d   = int'(tbl[s][3:0]);
      n   = (d + 1) * DT;
      p   = 1 + n + GT;
      r.is_done = 1'b0; r.step = s;
      if (cut >= 0 && off + p - 1 >= cut) begin
        b = cut - off + 1;
        if (b >= 2) m_hp = (hpf == 0) ? 1 : hpf;
        r.hp  = m_hp;
        r.cyc = b;
        r.act = (hpf == 0) ? 0 : ((b - 1 < n) ? b - 1 : n);
        r.first = (r.act > 0) ? 1 : -1;
        exp_q.push_back(r);
        m_step = s;
        return;
      end
      m_hp  = (hpf == 0) ? 1 : hpf;
      r.hp  = m_hp;
      r.cyc = p;
      r.act = (hpf == 0) ? 0 : n;
      r.first = (r.act > 0) ? 1 : -1;
      exp_q.push_back(r);
      m_step = s;
      off += p;
      if (s == len) begin
        exp_q.push_back(done_rec());
        if (!loop_mode) return;
        s = 0;
      end else begin
        s = (s + 1) % 16;
      end
    end
  endtask

  task automatic emit(input rec_t g);
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected got %s required nothing", fmt(g));
      return;
    end
    e = exp_q.pop_front();
    if (g.is_done != e.is_done || g.step != e.step || g.hp != e.hp ||
        g.act != e.act || g.first != e.first || g.cyc != e.cyc) begin
      errors++;
      $display("FAIL sb_record got %s required %s", fmt(g), fmt(e));
    end else begin
      $display("TXN %s", fmt(g));
    end
  endtask

  task automatic monitor_loop();
    bit   in_seg;
    rec_t cur;
    in_seg = 1'b0;
    cur.is_done = 1'b0; cur.step = 0; cur.hp = 0; cur.act = 0; cur.first = -1; cur.cyc = 0;
    forever begin
      @(negedge synth_clk);
      if (busy === 1'b1) begin
        if (in_seg && int'(step) != cur.step) begin
          emit(cur);
          in_seg = 1'b0;
        end
        if (!in_seg) begin
          in_seg = 1'b1;
          cur.step = int'(step); cur.act = 0; cur.first = -1; cur.cyc = 0; cur.hp = 0;
        end
        if (active === 1'b1) begin
          if (cur.first < 0) cur.first = cur.cyc;
          cur.act++;
        end
        if (hp == 7'd0) hp_zero_seen++;
        cur.hp = int'(hp);
        cur.cyc++;
      end else if (in_seg) begin
        emit(cur);
        in_seg = 1'b0;
      end
      if (done === 1'b1) emit(done_rec());
    end
  endtask

  task automatic tick();
    @(posedge synth_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wr(input int a, input logic [10:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    tbl[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    for (int i = 0; i < 16; i++) tbl[i] = '0;

    repeat (3) @(posedge synth_clk);
    #1;
    chk("rst_hp", 32'(hp), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // single note, hp=10, dur=1
    wr(0, {7'd10, 4'd1});
    len_m1 = 4'd0;
    model_pass(0, -1, 0);
    pulse_start();
    chk("t1_load_busy", 32'(busy), 1);
    chk("t1_load_active", 32'(active), 0);
    tick();
    chk("t1_play_active", 32'(active), 1);
    chk("t1_play_hp", 32'(hp), 10);
    wait_idle(200);
    chk("t1_done", 32'(done), 1);
    chk("t1_step_held", 32'(step), 0);

    // three steps including a rest
    wr(0, {7'd5, 4'd0});
    wr(1, {7'd0, 4'd2});
    wr(2, {7'd9, 4'd3});
    len_m1 = 4'd2;
    model_pass(2, -1, 0);
    pulse_start();
    wait_idle(300);
    chk("t2_step_held", 32'(step), 2);

    // stop during the rest step, then restart
    model_pass(2, 10, 0);
    pulse_start();
    repeat (10) tick();
    do_stop();
    chk("t3_busy", 32'(busy), 0);
    chk("t3_active", 32'(active), 0);
    chk("t3_step_held", 32'(step), 32'(m_step));
    chk("t3_done", 32'(done), 0);
    repeat (3) tick();
    model_pass(2, -1, 0);
    pulse_start();
    chk("t3_restart_step", 32'(step), 0);
    wait_idle(300);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_busy", 32'(busy), 0);
      tick();
    end

    // overwrite the playing step, hear it next pass, then async reset mid-note
    model_pass(2, -1, 0);
    pulse_start();
    repeat (10) tick();
    wr(1, {7'd20, 4'd1});
    wait_idle(300);
    model_pass(2, -1, 0);
    pulse_start();
    wait_idle(300);
    model_pass(2, 11, 0);
    pulse_start();
    repeat (12) tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_active", 32'(active), 0);
    chk("t5_rst_hp", 32'(hp), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_step", 32'(step), 0);
    chk("t5_rst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    m_hp = 1;
    m_step = 0;
    tick();

    // start while busy
    wr(0, {7'd6, 4'd0});
    wr(1, {7'd8, 4'd1});
    len_m1 = 4'd1;
`ifdef SEQ_LOOP_EN
    model_pass(1, 47, 1);
    pulse_start();
    repeat (47) tick();
    model_pass(1, 20, 1);
    pulse_start();
    chk("t6_restart_step", 32'(step), 0);
    repeat (20) tick();
    do_stop();
    chk("t6_stop_busy", 32'(busy), 0);
    chk("t6_stop_step", 32'(step), 32'(m_step));
`else
    model_pass(1, -1, 0);
    pulse_start();
    repeat (10) tick();
    pulse_start();
    chk("t6_ignored_busy", 32'(busy), 1);
    wait_idle(300);
    chk("t6_step_held", 32'(step), 1);
`endif

    // randomized tables, lengths and stop points
    for (int it = 0; it < 10; it++) begin : rnd
      int len, total, cut;
      len = int'($urandom_range(0, 3));
      total = 0;
      for (int a = 0; a <= len; a++) begin
        logic [6:0] hv;
        logic [3:0] dv;
        hv = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        dv = 4'($urandom_range(0, 3));
        wr(a, {hv, dv});
        total += 1 + (int'(dv) + 1) * DT + GT;
      end
      len_m1 = AW'(len);
      cut = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
      model_pass(len, cut, 0);
      pulse_start();
      if (cut >= 0) begin
        repeat (cut) tick();
        do_stop();
        chk("rnd_stop_busy", 32'(busy), 0);
        chk("rnd_stop_active", 32'(active), 0);
        chk("rnd_stop_step", 32'(step), 32'(m_step));
      end else begin
        wait_idle(400);
        chk("rnd_end_step", 32'(step), 32'(len));
      end
      tick();
    end

    repeat (4) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("hp_never_zero", 32'(hp_zero_seen), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
